// File: rtl/veer_sram_bank_model.sv
// Multi-bank SRAM model with power-up clearing FSM and a pipelined read path.
// Each bank stores {ecc, data} words. The INIT state zeroes every address of all banks,
// one address per clock. After that, init_done is high and user accesses are accepted.
// Read results hold on the outputs until a newer result leaves the pipeline.
// Optional feature: define VEER_SRAM_ERR_INJECT_EN to add one-shot read-bit-flip injection.
module veer_sram_bank_model #(
    parameter int unsigned NUM_BANKS    = 4,
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ECC_W        = 7,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_l,
    input  logic [NUM_BANKS-1:0]                 clken,
    input  logic [NUM_BANKS-1:0]                 wren_bank,
    input  logic [NUM_BANKS-1:0][ADDR_W-1:0]     addr_bank,
    input  logic [NUM_BANKS-1:0][DATA_W-1:0]     wr_data_bank,
    input  logic [NUM_BANKS-1:0][ECC_W-1:0]      wr_ecc_bank,
`ifdef VEER_SRAM_ERR_INJECT_EN
    input  logic                                 err_inj_req,
    input  logic [$clog2(NUM_BANKS)-1:0]         err_inj_bank,
    input  logic [$clog2(DATA_W+ECC_W)-1:0]      err_inj_bit,
`endif
    output logic [NUM_BANKS-1:0][DATA_W-1:0]     bank_dout,
    output logic [NUM_BANKS-1:0][ECC_W-1:0]      bank_ecc,
    output logic                                 init_done
);

    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned WORD_W = DATA_W + ECC_W;

    typedef logic [WORD_W-1:0] word_t;
    typedef enum logic [0:0] {StInit, StReady} state_e;

    state_e              state_q, state_d;
    // MSB set means the last address has been cleared; READY follows on the next clock
    logic [ADDR_W:0]     init_cnt_q, init_cnt_d;
    logic                init_wr;

    word_t               mem [NUM_BANKS][DEPTH];
    logic [NUM_BANKS-1:0]             mem_we;
    logic [NUM_BANKS-1:0][ADDR_W-1:0] mem_waddr;
    word_t               mem_wdata [NUM_BANKS];
    logic [NUM_BANKS-1:0] rd_req;
    word_t               rd_word [NUM_BANKS];

    logic [NUM_BANKS-1:0][READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    word_t               pipe_data_q [NUM_BANKS][READ_LATENCY];
    word_t               pipe_data_d [NUM_BANKS][READ_LATENCY];
    logic [NUM_BANKS-1:0] unused_last_vld;

`ifdef VEER_SRAM_ERR_INJECT_EN
    localparam int unsigned BANK_W = $clog2(NUM_BANKS);
    localparam int unsigned BIT_W  = $clog2(DATA_W + ECC_W);
    logic [NUM_BANKS-1:0]            inj_arm_q, inj_arm_d;
    logic [NUM_BANKS-1:0][BIT_W-1:0] inj_bit_q, inj_bit_d;
`endif

    // Init FSM next state: walk the clear counter, then move to READY
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        unique case (state_q)
            StInit: begin
                if (init_cnt_q[ADDR_W]) begin
                    state_d = StReady;
                end else begin
                    init_cnt_d = init_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
                end
            end
            StReady: ;
            default: state_d = StInit;
        endcase
    end

    // Init FSM outputs
    always_comb begin
        init_done = (state_q == StReady);
        init_wr   = (state_q == StInit) && !init_cnt_q[ADDR_W];
    end

    // Array port muxing: INIT clears, READY takes user traffic
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            mem_we[b]    = 1'b0;
            mem_waddr[b] = addr_bank[b];
            mem_wdata[b] = {wr_ecc_bank[b], wr_data_bank[b]};
            rd_req[b]    = init_done && clken[b] && !wren_bank[b];
            rd_word[b]   = mem[b][addr_bank[b]];
            if (init_wr) begin
                mem_we[b]    = 1'b1;
                mem_waddr[b] = init_cnt_q[ADDR_W-1:0];
                mem_wdata[b] = '0;
            end else if (init_done && clken[b] && wren_bank[b]) begin
                mem_we[b] = 1'b1;
            end
        end
    end

    // Read pipeline: the last stage doubles as the held output register
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            pipe_vld_d[b][0]  = rd_req[b];
            pipe_data_d[b][0] = rd_req[b] ? rd_word[b] : pipe_data_q[b][0];
            for (int s = 1; s < READ_LATENCY; s++) begin
                pipe_vld_d[b][s]  = pipe_vld_q[b][s-1];
                pipe_data_d[b][s] = pipe_vld_q[b][s-1] ? pipe_data_q[b][s-1]
                                                       : pipe_data_q[b][s];
            end
            unused_last_vld[b] = pipe_vld_q[b][READ_LATENCY-1];
        end
`ifdef VEER_SRAM_ERR_INJECT_EN
        for (int b = 0; b < NUM_BANKS; b++) begin
            inj_arm_d[b] = inj_arm_q[b];
            inj_bit_d[b] = inj_bit_q[b];
            // Flip only the result entering the output stage, never the stored word
            if (inj_arm_q[b] && pipe_vld_d[b][READ_LATENCY-1]) begin
                pipe_data_d[b][READ_LATENCY-1] = pipe_data_d[b][READ_LATENCY-1]
                                                 ^ (word_t'(1) << inj_bit_q[b]);
                inj_arm_d[b] = 1'b0;
            end
            if (err_inj_req && (err_inj_bank == BANK_W'(b))) begin
                inj_arm_d[b] = 1'b1;
                inj_bit_d[b] = err_inj_bit;
            end
        end
`endif
    end

    // Output unpacking from the last pipeline stage
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_dout[b] = pipe_data_q[b][READ_LATENCY-1][DATA_W-1:0];
            bank_ecc[b]  = pipe_data_q[b][READ_LATENCY-1][WORD_W-1:DATA_W];
        end
    end

    // State, pipeline and injection registers
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q    <= StInit;
            init_cnt_q <= '0;
            pipe_vld_q <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int s = 0; s < READ_LATENCY; s++) begin
                    pipe_data_q[b][s] <= '0;
                end
            end
`ifdef VEER_SRAM_ERR_INJECT_EN
            inj_arm_q <= '0;
            inj_bit_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            pipe_vld_q <= pipe_vld_d;
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int s = 0; s < READ_LATENCY; s++) begin
                    pipe_data_q[b][s] <= pipe_data_d[b][s];
                end
            end
`ifdef VEER_SRAM_ERR_INJECT_EN
            inj_arm_q <= inj_arm_d;
            inj_bit_q <= inj_bit_d;
`endif
        end
    end

    // Array storage is never reset; INIT is the only clearing mechanism
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (mem_we[b]) begin
                mem[b][mem_waddr[b]] <= mem_wdata[b];
            end
        end
    end

endmodule

// File: tb/tb_veer_sram_bank_model.sv
// Directed bench for veer_sram_bank_model (4 banks, ADDR_W=4, READ_LATENCY=3).
// Read expectations come from a reference array and are queued with their due cycle.
module tb_veer_sram_bank_model;

    localparam int NB = 4;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int EW = 7;
    localparam int RL = 3;
    localparam int DEPTH = 1 << AW;

    logic                     clk = 1'b0;
    logic                     rst_l;
    logic [NB-1:0]            clken, wren_bank;
    logic [NB-1:0][AW-1:0]    addr_bank;
    logic [NB-1:0][DW-1:0]    wr_data_bank;
    logic [NB-1:0][EW-1:0]    wr_ecc_bank;
    logic [NB-1:0][DW-1:0]    bank_dout;
    logic [NB-1:0][EW-1:0]    bank_ecc;
    logic                     init_done;
`ifdef VEER_SRAM_ERR_INJECT_EN
    logic                     err_inj_req;
    logic [1:0]               err_inj_bank;
    logic [5:0]               err_inj_bit;
`endif

    typedef struct {
        int            due;
        int            bank;
        logic [DW-1:0] d;
        logic [EW-1:0] e;
    } sb_t;

    sb_t               sbq[$];
    logic [DW+EW-1:0]  ref_mem [NB][DEPTH];
    logic              tb_arm [NB];
    int                tb_bit [NB];
    int                cyc = 0;
    int                checks = 0;
    int                failures = 0;

    veer_sram_bank_model #(
        .NUM_BANKS   (NB),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .ECC_W       (EW),
        .READ_LATENCY(RL)
    ) dut (
        .clk         (clk),
        .rst_l       (rst_l),
        .clken       (clken),
        .wren_bank   (wren_bank),
        .addr_bank   (addr_bank),
        .wr_data_bank(wr_data_bank),
        .wr_ecc_bank (wr_ecc_bank),
`ifdef VEER_SRAM_ERR_INJECT_EN
        .err_inj_req (err_inj_req),
        .err_inj_bank(err_inj_bank),
        .err_inj_bit (err_inj_bit),
`endif
        .bank_dout   (bank_dout),
        .bank_ecc    (bank_ecc),
        .init_done   (init_done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample #1 after the edge, idle the inputs, retire due scoreboard entries
    task automatic tick();
        sb_t s;
        @(posedge clk);
        cyc++;
        #1;
        clken        = '0;
        wren_bank    = NB'($urandom);
        addr_bank    = (NB*AW)'($urandom);
`ifdef VEER_SRAM_ERR_INJECT_EN
        err_inj_req  = 1'b0;
`endif
        while (sbq.size() > 0 && sbq[0].due == cyc) begin
            s = sbq.pop_front();
            chk($sformatf("rd_data_b%0d", s.bank), 64'(bank_dout[s.bank]), 64'(s.d));
            chk($sformatf("rd_ecc_b%0d", s.bank), 64'(bank_ecc[s.bank]), 64'(s.e));
        end
    endtask

    task automatic set_rd(input int b, input int a);
        logic [DW+EW-1:0] w;
        clken[b]     = 1'b1;
        wren_bank[b] = 1'b0;
        addr_bank[b] = AW'(a);
        w = ref_mem[b][a];
        if (tb_arm[b]) begin
            w[tb_bit[b]] = ~w[tb_bit[b]];
            tb_arm[b] = 1'b0;
        end
        sbq.push_back('{cyc + RL, b, w[DW-1:0], w[DW+EW-1:DW]});
    endtask

    task automatic set_wr(input int b, input int a, input logic [DW-1:0] d, input logic [EW-1:0] e);
        clken[b]        = 1'b1;
        wren_bank[b]    = 1'b1;
        addr_bank[b]    = AW'(a);
        wr_data_bank[b] = d;
        wr_ecc_bank[b]  = e;
        ref_mem[b][a]   = {e, d};
    endtask

    task automatic clear_model();
        for (int b = 0; b < NB; b++) begin
            tb_arm[b] = 1'b0;
            tb_bit[b] = 0;
            for (int a = 0; a < DEPTH; a++) ref_mem[b][a] = '0;
        end
        sbq.delete();
    endtask

    // Run n init clocks with ignored traffic; init_done must rise exactly on clock 17
    task automatic init_seq(input int n);
        for (int i = 1; i <= n; i++) begin
            clken        = '1;
            wren_bank    = 4'b0101;
            addr_bank    = (NB*AW)'($urandom);
            wr_data_bank = '1;
            wr_ecc_bank  = '1;
            tick();
            chk($sformatf("init_done_clk%0d", i), 64'(init_done), 64'(i == DEPTH + 1));
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        for (int b = 0; b < NB; b++) begin
            chk($sformatf("%s_dout_b%0d", tag, b), 64'(bank_dout[b]), 64'd0);
            chk($sformatf("%s_ecc_b%0d", tag, b), 64'(bank_ecc[b]), 64'd0);
        end
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) begin
            for (int b = 0; b < NB; b++) set_rd(b, a);
            tick();
        end
        repeat (RL) tick();
    endtask

    initial begin
        rst_l        = 1'b0;
        clken        = '0;
        wren_bank    = '0;
        addr_bank    = '0;
        wr_data_bank = '0;
        wr_ecc_bank  = '0;
`ifdef VEER_SRAM_ERR_INJECT_EN
        err_inj_req  = 1'b0;
        err_inj_bank = '0;
        err_inj_bit  = '0;
`endif
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        chk("reset_init_done", 64'(init_done), 64'd0);

        // Power-up clear, then every address reads back zero
        @(negedge clk);
        rst_l = 1'b1;
        init_seq(DEPTH + 1);
        check_zero_outputs("post_init");
        read_all();

        // Write then read next clock with latency 3, result held afterwards
        set_wr(1, 5, 32'hDEAD_BEEF, 7'h2A);
        tick();
        set_rd(1, 5);
        tick();
        tick();
        chk("lat_early_dout", 64'(bank_dout[1]), 64'd0);
        tick();
        repeat (3) tick();
        chk("lat_hold_dout", 64'(bank_dout[1]), 64'hDEAD_BEEF);
        chk("lat_hold_ecc", 64'(bank_ecc[1]), 64'h2A);

        // Back-to-back reads stream out in order
        for (int a = 0; a < 4; a++) begin
            set_wr(3, a, 32'hA5A5_0000 | 32'(a * 17 + 3), EW'(a + 9));
            tick();
        end
        for (int a = 0; a < 4; a++) begin
            set_rd(3, a);
            tick();
        end
        repeat (RL) tick();

        // Bank independence: write bank 0 while reading bank 2 at the same address
        set_wr(2, 7, 32'h2222_7777, 7'h22);
        set_wr(0, 7, 32'h0000_0707, 7'h07);
        tick();
        set_rd(0, 7);
        tick();
        repeat (RL) tick();
        set_wr(0, 7, 32'hBAD0_0000, 7'h55);
        set_rd(2, 7);
        tick();
        repeat (RL) tick();
        chk("wr_no_dout", 64'(bank_dout[0]), 64'h707);
        chk("wr_no_ecc", 64'(bank_ecc[0]), 64'h07);
        set_rd(0, 7);
        tick();
        repeat (RL) tick();

`ifdef VEER_SRAM_ERR_INJECT_EN
        // One-shot data flip, then clean re-read
        set_wr(1, 9, 32'h0000_0010, 7'h00);
        tick();
        err_inj_req = 1'b1; err_inj_bank = 2'd1; err_inj_bit = 6'd0;
        tb_arm[1] = 1'b1; tb_bit[1] = 0;
        tick();
        set_rd(1, 9);
        set_rd(0, 7);
        tick();
        repeat (RL) tick();
        set_rd(1, 9);
        tick();
        repeat (RL) tick();
        // Re-arm overwrites the bit; ECC bit 3 flips instead of data bit 4
        err_inj_req = 1'b1; err_inj_bank = 2'd1; err_inj_bit = 6'd4;
        tick();
        err_inj_req = 1'b1; err_inj_bank = 2'd1; err_inj_bit = 6'(DW + 3);
        tb_arm[1] = 1'b1; tb_bit[1] = DW + 3;
        tick();
        set_rd(1, 9);
        tick();
        repeat (RL) tick();
`endif

        // Reset with two reads in flight: immediate clear, no stale result afterwards
        set_rd(1, 5);
        tick();
        set_rd(1, 5);
        tick();
        rst_l = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        chk("async_rst_init_done", 64'(init_done), 64'd0);
        clear_model();
        @(negedge clk);
        rst_l = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("no_stale_dout", 64'(bank_dout[1]), 64'd0);
        end

        // Reset mid-INIT: init restarts from address 0
        rst_l = 1'b0;
        #1;
        @(negedge clk);
        rst_l = 1'b1;
        init_seq(8);
        rst_l = 1'b0;
        #1;
        chk("mid_init_rst_done", 64'(init_done), 64'd0);
        @(negedge clk);
        rst_l = 1'b1;
        init_seq(DEPTH + 1);
        check_zero_outputs("reinit");
        read_all();

        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/veer_sram_bank_model.md
VEER_SRAM_BANK_MODEL -- requirements
Module: veer_sram_bank_model

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 4: number of independent banks.
REQ-002 SHALL have parameter ADDR_W, default 10: per-bank word address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter DATA_W, default 32: data width per bank.
REQ-004 SHALL have parameter ECC_W, default 7: ECC width per bank.
REQ-005 SHALL have parameter READ_LATENCY, default 1, legal 1..4: clocks from read request to data.
REQ-006 SHALL have ports: clk  in  1  core clock (one clock domain); rst_l  in  1  asynchronous active-low reset.
REQ-007 SHALL have ports: clken  in  NUM_BANKS  per-bank access enable; wren_bank  in  NUM_BANKS  per-bank write enable.
REQ-008 SHALL have ports: addr_bank  in  NUM_BANKS x ADDR_W  word address; wr_data_bank  in  NUM_BANKS x DATA_W  write data; wr_ecc_bank  in  NUM_BANKS x ECC_W  write ECC.
REQ-009 SHALL have ports: bank_dout  out  NUM_BANKS x DATA_W  read data; bank_ecc  out  NUM_BANKS x ECC_W  read ECC; init_done  out  1  memory cleared and ready.

Function
REQ-010 SHALL run a two-state init FSM, INIT -> READY; INIT writes zero data and zero ECC to address 0..2**ADDR_W-1 of all banks in parallel, one address per clock.
REQ-011 SHALL leave INIT for READY on the clock after writing address 2**ADDR_W-1; init_done SHALL assert in READY and stay high until reset.
REQ-012 SHALL ignore clken/wren_bank during INIT; no read result is produced and no user write is applied.
REQ-013 In READY, clken=1 and wren_bank=0 on a bank SHALL be a read; bank data and ECC appear on bank_dout/bank_ecc exactly READ_LATENCY clocks later.
REQ-014 In READY, clken=1 and wren_bank=1 SHALL write wr_data_bank and wr_ecc_bank at the sampled edge; bank_dout/bank_ecc SHALL not change as a result of the write.
REQ-015 clken=0 SHALL make wren_bank and addr_bank don't-care; no access.
REQ-016 Read outputs SHALL hold the last read result until a newer read result emerges from the pipeline (SRAM hold semantics).
REQ-017 Back-to-back reads SHALL be fully pipelined: one result per clock per bank, in request order.
REQ-018 A read issued in the clock after a write to the same address SHALL return the new data; a read in the same clock as nothing else on that bank returns stored contents.
REQ-019 Banks SHALL operate independently; simultaneous accesses to different banks SHALL not interact.
REQ-020 A read pipeline SHALL be READ_LATENCY stages of valid+data per bank; READ_LATENCY=1 is a plain registered SRAM read.

Reset
REQ-021 rst_l low SHALL asynchronously force FSM to INIT, init address counter to 0, init_done to 0, all pipeline valids to 0, bank_dout and bank_ecc to 0.
REQ-022 Reset asserted mid-INIT or mid-read SHALL discard in-flight reads; after release init restarts from address 0.
REQ-023 Memory array contents SHALL not be reset directly; clearing is done only by INIT.

Configuration
REQ-024 Macro VEER_SRAM_ERR_INJECT_EN SHALL, when defined, add ports err_inj_req (in, 1), err_inj_bank (in, $clog2(NUM_BANKS)), err_inj_bit (in, $clog2(DATA_W+ECC_W)).
REQ-025 With the macro, err_inj_req=1 SHALL arm a one-shot flag on err_inj_bank latching err_inj_bit; the next read result emerging on that bank has that bit inverted (bits 0..DATA_W-1 data, above that ECC), then the flag clears; re-arming while armed overwrites the bit; reset clears flags; stored contents are never modified.
REQ-026 Without the macro, ports and injection logic SHALL be absent and reads are always uncorrupted.

Verification
REQ-027 Reset release, ADDR_W=4 -> init_done rises exactly 17 clocks after first clock edge with rst_l high; reads of every address then return 0 data, 0 ECC.
REQ-028 READ_LATENCY=3: write 0xDEADBEEF/ECC 0x2A to bank 1 addr 5, read addr 5 next clock -> bank_dout[1]=0xDEADBEEF, bank_ecc[1]=0x2A exactly 3 clocks after read, held thereafter.
REQ-029 Reads to addr 0,1,2,3 on consecutive clocks holding distinct data -> four results on four consecutive clocks, in order.
REQ-030 Simultaneous write bank 0 and read bank 2 same address -> bank_dout[0] unchanged, bank_dout[2] returns prior bank-2 contents.
REQ-031 rst_l pulsed low with two reads in flight mid-INIT -> outputs 0 immediately, no stale result after release, init restarts at 0.
REQ-032 Macro defined: arm bank 1 bit 0, read stored 0x00000010 -> bank_dout[1]=0x00000011 once; repeat read -> 0x00000010.
